phv_queue_arbiter: RTL and testbench
====================================

PHV_QUEUE_ARBITER -- requirements
Module: phv_queue_arbiter

Interface
REQ-001 Parameter PHV_LEN, default 1024, width of one packet header vector.
REQ-002 Parameter C_NUM_QUEUES, default 4, number of per-queue PHV FIFOs drained; this revision supports only 4.
REQ-003 Port axis_clk, input, 1: the single clock; all logic SHALL be rising-edge synchronous to it.
REQ-004 Port aresetn, input, 1: reset, synchronous and active-low.
REQ-005 Ports phv_in_0..phv_in_3, input, PHV_LEN each: fall-through FIFO data heads, one per queue.
REQ-006 Ports phv_empty_0..phv_empty_3, input, 1 each: FIFO empty flags.
REQ-007 Ports phv_rd_en_0..phv_rd_en_3, output, 1 each: FIFO pops.
REQ-008 Port phv_out, output, PHV_LEN: arbitrated PHV.
REQ-009 Port phv_out_valid, output, 1: phv_out holds a valid PHV.
REQ-010 Port phv_out_ready, input, 1: downstream accepts phv_out.
REQ-011 Port queue_id_out, output, 2: index of the queue phv_out came from.
REQ-012 Ports grant_cnt_0..grant_cnt_3, output, 32 each: per-queue count of PHVs delivered downstream.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and SEND, with one output holding register (phv_out, queue_id_out).
REQ-014 In IDLE with every phv_empty_i high, the block SHALL stay in IDLE with all phv_rd_en_i low.
REQ-015 In IDLE with any phv_empty_i low, the block SHALL grant the first non-empty queue in round-robin order starting at last_grant+1 (mod 4).
REQ-016 On a grant, the block SHALL, in the same cycle:
- assert the granted phv_rd_en_i for exactly one cycle;
- capture phv_in_i into phv_out;
- load queue_id_out with i;
- update last_grant to i;
- enter SEND.
REQ-017 phv_rd_en_0..3 SHALL be combinational from FIFO state, one-hot or all-zero, and never asserted for an empty queue.
REQ-018 In SEND, phv_out_valid SHALL be 1, and phv_out and queue_id_out SHALL stay stable until phv_out_ready is high.
REQ-019 Handshake: in a SEND cycle with phv_out_ready high, grant_cnt[queue_id_out] SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-020 On a SEND handshake with any queue non-empty, the block SHALL grant the next queue in the same cycle per REQ-015/016 and remain in SEND, giving back-to-back throughput of one PHV per cycle.
REQ-021 On a SEND handshake with all queues empty, the block SHALL enter IDLE and deassert phv_out_valid on the next cycle.
REQ-022 Latency: a queue becoming non-empty while in IDLE at cycle N SHALL produce phv_out_valid=1 at cycle N+1.
REQ-023 Fairness: with all four queues continuously non-empty and ready held high, grants SHALL rotate 0,1,2,3,0,...
REQ-024 A queue that goes non-empty while the block waits in SEND with ready low SHALL NOT be popped until the handshake.
REQ-025 The block SHALL NOT check that PHV bits [141+:4] match the granted queue; content is forwarded unmodified.

Reset
REQ-026 While aresetn is low at a clock edge, the block SHALL set:
- state IDLE;
- phv_out_valid 0, phv_out 0, queue_id_out 0;
- last_grant 3, so queue 0 has first priority;
- all grant_cnt_i 0.
REQ-027 While aresetn is low, all phv_rd_en_i SHALL be 0.
REQ-028 A reset asserted during SEND SHALL discard the held PHV without counting it and without popping any FIFO.

Verification
REQ-029 Reset, then queue 2 alone non-empty with head 0xA5 and ready high -> phv_rd_en_2 pulses one cycle; next cycle phv_out=0xA5, queue_id_out=2, valid=1; grant_cnt_2=1 after the handshake.
REQ-030 All four queues hold 3 PHVs each, ready always high -> 12 consecutive valid cycles, queue_id_out sequence 0,1,2,3 repeated 3 times, each grant_cnt=3, no idle cycle.
REQ-031 Queue 1 non-empty, ready held low 5 cycles -> phv_out and queue_id_out stable; phv_rd_en_1 asserted only once; no counter change until ready rises.
REQ-032 Queues 0 and 3 non-empty, last_grant=0 -> queue 3 granted before queue 0.
REQ-033 aresetn low for 1 cycle during SEND -> next cycle valid=0, counters 0, no rd_en pulse; queue 0 is then granted first.
REQ-034 Preload grant_cnt_0 to 0xFFFFFFFF via a long run or a force, then one more queue-0 handshake -> grant_cnt_0=0.

Source files
------------

// File: rtl/phv_queue_arbiter.sv
// Round-robin arbiter draining four fall-through PHV FIFOs into one
// valid/ready output register, with per-queue delivery counters.
module phv_queue_arbiter #(
  parameter int unsigned PHV_LEN      = 1024,
  parameter int unsigned C_NUM_QUEUES = 4
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  input  logic [PHV_LEN-1:0] phv_in_0,
  input  logic [PHV_LEN-1:0] phv_in_1,
  input  logic [PHV_LEN-1:0] phv_in_2,
  input  logic [PHV_LEN-1:0] phv_in_3,
  input  logic               phv_empty_0,
  input  logic               phv_empty_1,
  input  logic               phv_empty_2,
  input  logic               phv_empty_3,
  output logic               phv_rd_en_0,
  output logic               phv_rd_en_1,
  output logic               phv_rd_en_2,
  output logic               phv_rd_en_3,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
  input  logic               phv_out_ready,
  output logic [1:0]         queue_id_out,
  output logic [31:0]        grant_cnt_0,
  output logic [31:0]        grant_cnt_1,
  output logic [31:0]        grant_cnt_2,
  output logic [31:0]        grant_cnt_3
);

  localparam int unsigned QW    = 2;
  localparam int unsigned CNT_W = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [C_NUM_QUEUES-1:0]              empty_v;
  logic [C_NUM_QUEUES-1:0][PHV_LEN-1:0] phv_in_v;

  logic [0:0]                           state_q, state_d;
  logic                                 valid_q, valid_d;
  logic [PHV_LEN-1:0]                   phv_out_q, phv_out_d;
  logic [QW-1:0]                        qid_q, qid_d;
  logic [QW-1:0]                        last_grant_q, last_grant_d;
  logic [C_NUM_QUEUES-1:0][CNT_W-1:0]   grant_cnt_q, grant_cnt_d;

  logic                                 can_grant;
  logic                                 handshake;
  logic                                 grant_vld;
  logic [QW-1:0]                        grant_idx;
  logic [QW-1:0]                        idx;
  logic [C_NUM_QUEUES-1:0]              rd_en_c;

  assign empty_v  = {phv_empty_3, phv_empty_2, phv_empty_1, phv_empty_0};
  assign phv_in_v = {phv_in_3, phv_in_2, phv_in_1, phv_in_0};

  // Pick the first non-empty queue after last_grant; pops are gated by reset
  always_comb begin
    can_grant = aresetn && ((state_q == IDLE) || phv_out_ready);
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    rd_en_c   = '0;
    if (can_grant) begin
      for (int unsigned k = 1; k <= C_NUM_QUEUES; k++) begin
        idx = last_grant_q + QW'(k);
        if (!grant_vld && !empty_v[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
    if (grant_vld) begin
      rd_en_c[grant_idx] = 1'b1;
    end
  end

  // Next-state: a new grant always wins over dropping back to IDLE
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    phv_out_d    = phv_out_q;
    qid_d        = qid_q;
    last_grant_d = last_grant_q;
    grant_cnt_d  = grant_cnt_q;
    handshake    = (state_q == SEND) && phv_out_ready;

    if (handshake) begin
      grant_cnt_d[qid_q] = grant_cnt_q[qid_q] + CNT_W'(1);
    end

    if (grant_vld) begin
      state_d      = SEND;
      valid_d      = 1'b1;
      phv_out_d    = phv_in_v[grant_idx];
      qid_d        = grant_idx;
      last_grant_d = grant_idx;
    end else if (handshake) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      phv_out_q    <= '0;
      qid_q        <= '0;
      last_grant_q <= QW'(3);
      grant_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      phv_out_q    <= phv_out_d;
      qid_q        <= qid_d;
      last_grant_q <= last_grant_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign phv_rd_en_0   = rd_en_c[0];
  assign phv_rd_en_1   = rd_en_c[1];
  assign phv_rd_en_2   = rd_en_c[2];
  assign phv_rd_en_3   = rd_en_c[3];
  assign phv_out       = phv_out_q;
  assign phv_out_valid = valid_q;
  assign queue_id_out  = qid_q;
  assign grant_cnt_0   = grant_cnt_q[0];
  assign grant_cnt_1   = grant_cnt_q[1];
  assign grant_cnt_2   = grant_cnt_q[2];
  assign grant_cnt_3   = grant_cnt_q[3];

endmodule

// File: tb/tb_phv_queue_arbiter.sv
// Directed bench for phv_queue_arbiter: four modelled fall-through FIFOs
// feed the arbiter; each task drives one scenario and checks inline.
module tb_phv_queue_arbiter;

  localparam int unsigned PHV_LEN = 1024;

  logic               axis_clk;
  logic               aresetn;
  logic [PHV_LEN-1:0] phv_in_0, phv_in_1, phv_in_2, phv_in_3;
  logic               phv_empty_0, phv_empty_1, phv_empty_2, phv_empty_3;
  logic               phv_rd_en_0, phv_rd_en_1, phv_rd_en_2, phv_rd_en_3;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic               phv_out_ready;
  logic [1:0]         queue_id_out;
  logic [31:0]        grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3;

  int checks = 0;
  int errors = 0;

  phv_queue_arbiter #(.PHV_LEN(PHV_LEN), .C_NUM_QUEUES(4)) dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .phv_in_0      (phv_in_0),
    .phv_in_1      (phv_in_1),
    .phv_in_2      (phv_in_2),
    .phv_in_3      (phv_in_3),
    .phv_empty_0   (phv_empty_0),
    .phv_empty_1   (phv_empty_1),
    .phv_empty_2   (phv_empty_2),
    .phv_empty_3   (phv_empty_3),
    .phv_rd_en_0   (phv_rd_en_0),
    .phv_rd_en_1   (phv_rd_en_1),
    .phv_rd_en_2   (phv_rd_en_2),
    .phv_rd_en_3   (phv_rd_en_3),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .phv_out_ready (phv_out_ready),
    .queue_id_out  (queue_id_out),
    .grant_cnt_0   (grant_cnt_0),
    .grant_cnt_1   (grant_cnt_1),
    .grant_cnt_2   (grant_cnt_2),
    .grant_cnt_3   (grant_cnt_3)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // FIFO model: tasks write, the posedge process pops on rd_en
  logic [PHV_LEN-1:0] mem [4][64];
  logic [5:0]         wr_ptr [4] = '{default: 6'd0};
  logic [5:0]         rd_ptr [4] = '{default: 6'd0};
  int                 pop_cnt [4] = '{default: 0};
  int                 viol = 0;
  logic [3:0]         rd, emp;
  logic [3:0][31:0]   gcnt;

  assign phv_in_0    = mem[0][rd_ptr[0]];
  assign phv_in_1    = mem[1][rd_ptr[1]];
  assign phv_in_2    = mem[2][rd_ptr[2]];
  assign phv_in_3    = mem[3][rd_ptr[3]];
  assign phv_empty_0 = (wr_ptr[0] == rd_ptr[0]);
  assign phv_empty_1 = (wr_ptr[1] == rd_ptr[1]);
  assign phv_empty_2 = (wr_ptr[2] == rd_ptr[2]);
  assign phv_empty_3 = (wr_ptr[3] == rd_ptr[3]);
  assign rd   = {phv_rd_en_3, phv_rd_en_2, phv_rd_en_1, phv_rd_en_0};
  assign emp  = {phv_empty_3, phv_empty_2, phv_empty_1, phv_empty_0};
  assign gcnt = {grant_cnt_3, grant_cnt_2, grant_cnt_1, grant_cnt_0};

  always @(posedge axis_clk) begin
    if ($countones(rd) > 1) viol <= viol + 1;
    for (int q = 0; q < 4; q++) begin
      if (rd[q]) begin
        if (emp[q]) viol <= viol + 1;
        rd_ptr[q]  <= rd_ptr[q] + 6'd1;
        pop_cnt[q] <= pop_cnt[q] + 1;
      end
    end
  end

  task automatic push(input int q, input logic [31:0] v);
    mem[q][wr_ptr[q]] = PHV_LEN'(v);
    wr_ptr[q] = wr_ptr[q] + 6'd1;
  endtask

  task automatic do_reset();
    @(negedge axis_clk); aresetn = 1'b0;
    @(negedge axis_clk); aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; phv_out_ready = 1'b0;
    repeat (2) @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", phv_out_valid); end
    checks++; if (phv_out !== '0) begin errors++; $display("FAIL reset_phv_out: got %0h exp 0", phv_out); end
    checks++; if (queue_id_out !== 2'd0) begin errors++; $display("FAIL reset_qid: got %0d exp 0", queue_id_out); end
    checks++; if (gcnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0h exp 0", gcnt); end
    checks++; if (rd !== 4'b0) begin errors++; $display("FAIL reset_rd_en: got %b exp 0000", rd); end
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge axis_clk); phv_out_ready = 1'b1; push(2, 32'hA5);
    #1;
    checks++; if (rd !== 4'b0100) begin errors++; $display("FAIL single_rd_en: got %b exp 0100", rd); end
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b exp 1", phv_out_valid); end
    checks++; if (phv_out !== PHV_LEN'(32'hA5)) begin errors++; $display("FAIL single_phv: got %0h exp a5", phv_out); end
    checks++; if (queue_id_out !== 2'd2) begin errors++; $display("FAIL single_qid: got %0d exp 2", queue_id_out); end
    checks++; if (rd !== 4'b0) begin errors++; $display("FAIL single_rd_pulse: got %b exp 0000", rd); end
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b exp 0", phv_out_valid); end
    checks++; if (grant_cnt_2 !== 32'd1) begin errors++; $display("FAIL single_cnt2: got %0d exp 1", grant_cnt_2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int q = 0; q < 4; q++) push(q, 32'hB000 + 32'(q * 16 + k));
    phv_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge axis_clk);
      checks++; if (phv_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b exp 1", i, phv_out_valid); end
      checks++; if (queue_id_out !== 2'(i % 4)) begin errors++; $display("FAIL b2b_qid[%0d]: got %0d exp %0d", i, queue_id_out, i % 4); end
      checks++; if (phv_out !== PHV_LEN'(32'hB000 + 32'((i % 4) * 16 + i / 4))) begin errors++; $display("FAIL b2b_phv[%0d]: got %0h", i, phv_out[31:0]); end
    end
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %0b exp 0", phv_out_valid); end
    checks++; if (gcnt !== {32'd3, 32'd3, 32'd3, 32'd3}) begin errors++; $display("FAIL b2b_cnt: got %0h exp all 3", gcnt); end
  endtask

  task automatic test_hold();
    int p1;
    @(negedge axis_clk); phv_out_ready = 1'b0; p1 = pop_cnt[1]; push(1, 32'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      if (i == 0) push(1, 32'h12);
      #1;
      checks++; if (phv_out_valid !== 1'b1 || queue_id_out !== 2'd1 || phv_out !== PHV_LEN'(32'h11)) begin
        errors++; $display("FAIL hold_stable[%0d]: got v=%0b q=%0d d=%0h exp v=1 q=1 d=11", i, phv_out_valid, queue_id_out, phv_out[31:0]); end
      checks++; if (rd !== 4'b0) begin errors++; $display("FAIL hold_no_pop[%0d]: got %b exp 0000", i, rd); end
      checks++; if (grant_cnt_1 !== 32'd3) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d exp 3", i, grant_cnt_1); end
    end
    checks++; if (pop_cnt[1] - p1 !== 1) begin errors++; $display("FAIL hold_pops: got %0d exp 1", pop_cnt[1] - p1); end
    phv_out_ready = 1'b1; #1;
    checks++; if (rd !== 4'b0010) begin errors++; $display("FAIL hold_regrant: got %b exp 0010", rd); end
    @(negedge axis_clk);
    checks++; if (grant_cnt_1 !== 32'd4 || phv_out !== PHV_LEN'(32'h12) || phv_out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_release: got c=%0d d=%0h v=%0b exp c=4 d=12 v=1", grant_cnt_1, phv_out[31:0], phv_out_valid); end
    @(negedge axis_clk);
    checks++; if (grant_cnt_1 !== 32'd5 || phv_out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_done: got c=%0d v=%0b exp c=5 v=0", grant_cnt_1, phv_out_valid); end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge axis_clk); phv_out_ready = 1'b1; push(0, 32'h30);
    @(negedge axis_clk);
    checks++; if (queue_id_out !== 2'd0) begin errors++; $display("FAIL prio_first: got %0d exp 0", queue_id_out); end
    @(negedge axis_clk);
    push(0, 32'h31); push(3, 32'h33);
    @(negedge axis_clk);
    checks++; if (queue_id_out !== 2'd3 || phv_out !== PHV_LEN'(32'h33)) begin
      errors++; $display("FAIL prio_q3_first: got q=%0d d=%0h exp q=3 d=33", queue_id_out, phv_out[31:0]); end
    @(negedge axis_clk);
    checks++; if (queue_id_out !== 2'd0 || phv_out !== PHV_LEN'(32'h31)) begin
      errors++; $display("FAIL prio_q0_next: got q=%0d d=%0h exp q=0 d=31", queue_id_out, phv_out[31:0]); end
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b0 || gcnt !== {32'd1, 32'd0, 32'd0, 32'd2}) begin
      errors++; $display("FAIL prio_cnt: got v=%0b cnt=%0h exp v=0 cnt=1,0,0,2", phv_out_valid, gcnt); end
  endtask

  task automatic test_reset_in_send();
    int pops;
    @(negedge axis_clk); phv_out_ready = 1'b0; push(1, 32'h41);
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b1 || queue_id_out !== 2'd1) begin
      errors++; $display("FAIL rst_send_pre: got v=%0b q=%0d exp v=1 q=1", phv_out_valid, queue_id_out); end
    push(2, 32'h42);
    pops = pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3];
    @(negedge axis_clk); aresetn = 1'b0; phv_out_ready = 1'b1; #1;
    checks++; if (rd !== 4'b0) begin errors++; $display("FAIL rst_send_rd_en: got %b exp 0000", rd); end
    @(negedge axis_clk); aresetn = 1'b1; push(0, 32'h40);
    checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL rst_send_valid: got %0b exp 0", phv_out_valid); end
    checks++; if (gcnt !== '0) begin errors++; $display("FAIL rst_send_cnt: got %0h exp 0", gcnt); end
    checks++; if (pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3] !== pops) begin errors++; $display("FAIL rst_send_pops: got %0d exp %0d", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3], pops); end
    #1;
    checks++; if (rd !== 4'b0001) begin errors++; $display("FAIL rst_send_q0_grant: got %b exp 0001", rd); end
    @(negedge axis_clk);
    checks++; if (queue_id_out !== 2'd0 || phv_out !== PHV_LEN'(32'h40)) begin
      errors++; $display("FAIL rst_send_q0: got q=%0d d=%0h exp q=0 d=40", queue_id_out, phv_out[31:0]); end
    @(negedge axis_clk);
    checks++; if (queue_id_out !== 2'd2 || phv_out !== PHV_LEN'(32'h42)) begin
      errors++; $display("FAIL rst_send_q2: got q=%0d d=%0h exp q=2 d=42", queue_id_out, phv_out[31:0]); end
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b0 || gcnt !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
      errors++; $display("FAIL rst_send_end: got v=%0b cnt=%0h exp v=0 cnt=0,1,0,1", phv_out_valid, gcnt); end
  endtask

  task automatic test_wrap();
    @(negedge axis_clk); phv_out_ready = 1'b0; push(0, 32'h50);
    @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b1 || queue_id_out !== 2'd0) begin
      errors++; $display("FAIL wrap_pre: got v=%0b q=%0d exp v=1 q=0", phv_out_valid, queue_id_out); end
    force dut.grant_cnt_q = {32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF};
    #1 release dut.grant_cnt_q;
    #1;
    checks++; if (grant_cnt_0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %0h exp ffffffff", grant_cnt_0); end
    phv_out_ready = 1'b1;
    @(negedge axis_clk);
    checks++; if (grant_cnt_0 !== 32'd0) begin errors++; $display("FAIL wrap_cnt0: got %0h exp 0", grant_cnt_0); end
    checks++; if (grant_cnt_2 !== 32'd1) begin errors++; $display("FAIL wrap_cnt2: got %0d exp 1", grant_cnt_2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_priority();
    test_reset_in_send();
    test_wrap();
    @(negedge axis_clk);
    checks++; if (viol !== 0) begin errors++; $display("FAIL rd_en_rules: got %0d violations exp 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
